// File: rtl/gx4000_mem_arbiter.sv
// Shared cartridge/ROM port scheduler for the GX4000/Plus path: CPU (r/w), sound DMA
// and sprite fetcher (read-only) share one fixed-latency memory, one access at a time.
module gx4000_mem_arbiter #(
  parameter int ADDR_W     = 23,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_ack,
  output logic [7:0]        spr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_starve
);

  // Handshake: a req seen high in IDLE is a new request; once granted the access runs
  // to completion and acks for one cycle even if req falls; the requester drops req
  // the cycle after ack. Address/data are sampled only at the grant edge.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [1:0] OWN_SPR  = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] CNT_INIT   = 3'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        owner_q;
  logic              we_q;
  logic              rr_spr_q, rr_spr_d;
  logic [3:0]        starve_q, starve_d;

  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              spr_ack_q, spr_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        dma_rdata_q, dma_rdata_d;
  logic [7:0]        spr_rdata_q, spr_rdata_d;

  logic              ext_pend;
  logic              starved;
  logic [1:0]        arb_owner;
  logic [ADDR_W-1:0] arb_addr;

  // CPU has priority until it has won STARVE_MAX times in a row over a waiting DMA/sprite.
  always_comb begin
    ext_pend  = dma_req | spr_req;
    starved   = (starve_q == STARVE_LIM) && ext_pend;
    arb_owner = OWN_NONE;
    arb_addr  = cpu_addr;
    if (cpu_req && !starved) begin
      arb_owner = OWN_CPU;
    end else if (dma_req && (!rr_spr_q || !spr_req)) begin
      arb_owner = OWN_DMA;
      arb_addr  = dma_addr;
    end else if (spr_req) begin
      arb_owner = OWN_SPR;
      arb_addr  = spr_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    rr_spr_d = rr_spr_q;
    if (!ext_pend) begin
      starve_d = '0;
    end else if (state_q == S_IDLE) begin
      case (arb_owner)
        OWN_CPU: if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
        OWN_DMA: begin starve_d = '0; rr_spr_d = 1'b1; end
        OWN_SPR: begin starve_d = '0; rr_spr_d = 1'b0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (arb_owner != OWN_NONE) state_d = S_ISSUE;
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_ACK;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is registered, so its _d value is derived from the transition being taken.
  always_comb begin
    grant_d     = grant_q;
    busy_d      = (state_d != S_IDLE);
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    spr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    spr_rdata_d = spr_rdata_q;
    if (state_q == S_IDLE && arb_owner != OWN_NONE) begin
      grant_d    = arb_owner;
      mem_addr_d = arb_addr;
      if (arb_owner == OWN_CPU && cpu_we) begin
        mem_wr_d   = 1'b1;
        mem_data_d = cpu_wdata;
      end else begin
        mem_rd_d = 1'b1;
      end
    end
    if (state_q == S_WAIT && cnt_q == 3'd0) begin
      case (owner_q)
        OWN_CPU: cpu_rdata_d = mem_q;
        OWN_DMA: dma_rdata_d = mem_q;
        OWN_SPR: spr_rdata_d = mem_q;
        default: ;
      endcase
    end
    if (state_d == S_ACK) begin
      grant_d   = OWN_NONE;
      cpu_ack_d = (owner_q == OWN_CPU);
      dma_ack_d = (owner_q == OWN_DMA);
      spr_ack_d = (owner_q == OWN_SPR);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      rr_spr_q    <= 1'b0;
      starve_q    <= '0;
      grant_q     <= OWN_NONE;
      busy_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      spr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      spr_rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && arb_owner != OWN_NONE) begin
        owner_q <= arb_owner;
        we_q    <= (arb_owner == OWN_CPU) && cpu_we;
      end
      rr_spr_q    <= rr_spr_d;
      starve_q    <= starve_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      spr_ack_q   <= spr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      spr_rdata_q <= spr_rdata_d;
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign dma_ack    = dma_ack_q;
  assign spr_ack    = spr_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign spr_rdata  = spr_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wr     = mem_wr_q;
  assign mem_rd     = mem_rd_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;
  assign dbg_starve = starve_q;

endmodule

// File: tb/tb_gx4000_mem_arbiter.sv
// Directed bench for gx4000_mem_arbiter: latency, write path, arbitration order,
// starvation limit, mid-access reset and early req drop.
module tb_gx4000_mem_arbiter;

  localparam int ADDR_W  = 23;
  localparam int MEM_LAT = 2;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_ack;
  logic [7:0]        dma_rdata;
  logic              spr_req;
  logic [ADDR_W-1:0] spr_addr;
  logic              spr_ack;
  logic [7:0]        spr_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_wr, mem_rd;
  logic [7:0]        mem_q;
  logic [1:0]        grant;
  logic              busy;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_starve;

  gx4000_mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_rdata(spr_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_q(mem_q), .grant(grant), .busy(busy),
    .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;
  int n_rd = 0;
  int n_issue = 0;
  int n_overlap = 0;
  int n_outside = 0;
  logic [5:0] exp_q[$];
  logic [7:0] exp_cpu_rd, exp_dma_rd, exp_spr_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  // Memory contents: byte = a[7:0] ^ a[15:8] ^ 0xE5, valid only MEM_LAT cycles after mem_rd.
  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hE5;
  endfunction

  initial begin : mem_model
    int rd_age;
    logic [ADDR_W-1:0] rd_addr;
    mem_q   = 8'hEE;
    rd_age  = 99;
    rd_addr = '0;
    forever begin
      @(negedge clk_sys);
      if (mem_rd && mem_wr) n_overlap++;
      if ((mem_rd || mem_wr) && dbg_state != 2'd1) n_outside++;
      if (mem_rd || mem_wr) n_issue++;
      if (mem_rd) begin
        rd_age  = 0;
        rd_addr = mem_addr;
        n_rd++;
      end else if (rd_age < 99) begin
        rd_age++;
      end
      mem_q = (rd_age == MEM_LAT) ? mem_byte(rd_addr) : 8'hEE;
    end
  end

  // Scoreboard: each ack is compared against exp_q entries of {starve, owner}.
  task automatic run_acks(input int n, input bit drop_c, input bit drop_d, input bit drop_s);
    int seen;
    int cyc;
    logic [1:0] o;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < n * 16 + 20) begin
      step();
      cyc++;
      if (cpu_ack || dma_ack || spr_ack) begin
        o = cpu_ack ? 2'd1 : (dma_ack ? 2'd2 : 2'd3);
        if (exp_q.size() > 0) check("grant_order", {dbg_starve, o}, exp_q.pop_front());
        else                  check("extra_ack", {dbg_starve, o}, 6'd0);
        case (o)
          2'd1: begin check("cpu_rdata", cpu_rdata, exp_cpu_rd); if (drop_c) cpu_req = 1'b0; end
          2'd2: begin check("dma_rdata", dma_rdata, exp_dma_rd); if (drop_d) dma_req = 1'b0; end
          default: begin check("spr_rdata", spr_rdata, exp_spr_rd); if (drop_s) spr_req = 1'b0; end
        endcase
        seen++;
      end
    end
    check("ack_count", seen, n);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0; spr_req = 1'b0; spr_addr = '0;
    exp_cpu_rd = '0; exp_dma_rd = '0; exp_spr_rd = '0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    step();

    // reset state
    check("rst_grant", grant, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_strobes", {mem_rd, mem_wr}, 2'b00);
    check("rst_acks", {cpu_ack, dma_ack, spr_ack}, 3'b000);
    check("rst_mem_addr", mem_addr, 23'h0);
    check("rst_rdata", {cpu_rdata, dma_rdata, spr_rdata}, 24'h0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_starve", dbg_starve, 4'd0);

    // CPU read 0x004000, ack at cycle MEM_LAT+2 = 4
    cpu_addr = 23'h004000; cpu_we = 1'b0; cpu_req = 1'b1;
    step();
    check("rd_c1_mem_rd", mem_rd, 1'b1);
    check("rd_c1_grant", grant, 2'd1);
    check("rd_c1_addr", mem_addr, 23'h004000);
    check("rd_c1_busy", busy, 1'b1);
    step();
    check("rd_c2_mem_rd", mem_rd, 1'b0);
    check("rd_c2_grant_ack", {grant, cpu_ack}, 3'b010);
    step();
    check("rd_c3_grant_ack", {grant, cpu_ack}, 3'b010);
    step();
    check("rd_c4_ack", cpu_ack, 1'b1);
    check("rd_c4_grant", grant, 2'd0);
    check("rd_c4_rdata", cpu_rdata, 8'hA5);
    cpu_req = 1'b0;
    step();
    check("rd_c5_ack_low", cpu_ack, 1'b0);
    check("rd_c5_busy", busy, 1'b0);
    check("rd_c5_rdata_held", cpu_rdata, 8'hA5);
    check("rd_c5_addr_held", mem_addr, 23'h004000);

    // CPU write 0x000010 <= 0x3C, ack at cycle 2
    base = n_rd;
    cpu_addr = 23'h000010; cpu_wdata = 8'h3C; cpu_we = 1'b1; cpu_req = 1'b1;
    step();
    check("wr_c1_mem_wr", mem_wr, 1'b1);
    check("wr_c1_mem_rd", mem_rd, 1'b0);
    check("wr_c1_addr", mem_addr, 23'h000010);
    check("wr_c1_data", mem_data, 8'h3C);
    step();
    check("wr_c2_ack", cpu_ack, 1'b1);
    check("wr_c2_mem_wr", mem_wr, 1'b0);
    check("wr_c2_rdata_kept", cpu_rdata, 8'hA5);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    check("wr_c3_ack_low", cpu_ack, 1'b0);
    check("wr_no_read", n_rd - base, 0);

    // all three together: CPU, DMA, sprite
    cpu_addr = 23'h000300; dma_addr = 23'h000100; spr_addr = 23'h000200;
    exp_cpu_rd = 8'hE6; exp_dma_rd = 8'hE4; exp_spr_rd = 8'hE7;
    exp_q.push_back({4'd1, 2'd1});
    exp_q.push_back({4'd0, 2'd2});
    exp_q.push_back({4'd0, 2'd3});
    cpu_req = 1'b1; dma_req = 1'b1; spr_req = 1'b1;
    run_acks(3, 1'b1, 1'b1, 1'b1);
    step();

    // DMA and sprite held continuously alternate
    exp_q.push_back({4'd0, 2'd2});
    exp_q.push_back({4'd0, 2'd3});
    exp_q.push_back({4'd0, 2'd2});
    dma_req = 1'b1; spr_req = 1'b1;
    run_acks(3, 1'b0, 1'b0, 1'b0);
    dma_req = 1'b0; spr_req = 1'b0;
    step();
    step();
    check("starve_idle_clear", dbg_starve, 4'd0);

    // starvation limit: 4 CPU then 1 DMA, twice
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 4; k++) exp_q.push_back({4'(k), 2'd1});
      exp_q.push_back({4'd0, 2'd2});
    end
    cpu_req = 1'b1; dma_req = 1'b1;
    run_acks(10, 1'b0, 1'b0, 1'b0);
    cpu_req = 1'b0; dma_req = 1'b0;
    step();
    step();

    // reset during WAIT of a DMA read
    dma_addr = 23'h000123; dma_req = 1'b1;
    step();
    check("rst5_issue_grant", grant, 2'd2);
    step();
    check("rst5_in_wait", dbg_state, 2'd2);
    reset_n = 1'b0;
    #1;
    check("rst5_grant", grant, 2'd0);
    check("rst5_busy", busy, 1'b0);
    check("rst5_mem_addr", mem_addr, 23'h0);
    check("rst5_rdata", {cpu_rdata, dma_rdata, spr_rdata}, 24'h0);
    check("rst5_state", dbg_state, 2'd0);
    base = 0;
    repeat (4) begin
      step();
      if (dma_ack) base++;
    end
    check("rst5_no_ack", base, 0);
    reset_n = 1'b1;
    exp_dma_rd = 8'hC7;
    exp_q.push_back({4'd0, 2'd2});
    run_acks(1, 1'b0, 1'b1, 1'b0);
    step();

    // sprite drops req during WAIT: one ack, one access
    base = n_issue;
    spr_addr = 23'h000055; spr_req = 1'b1;
    exp_spr_rd = 8'hB0;
    step();
    step();
    spr_req = 1'b0;
    exp_q.push_back({4'd0, 2'd3});
    run_acks(1, 1'b0, 1'b0, 1'b1);
    repeat (5) step();
    check("drop_one_access", n_issue - base, 1);
    check("drop_idle", {busy, spr_ack}, 2'b00);

    check("exp_q_drained", exp_q.size(), 0);
    check("rd_wr_overlap", n_overlap, 0);
    check("strobe_outside_issue", n_outside, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gx4000_mem_arbiter.md
Name: gx4000_mem_arbiter

Overview:
- Single-port scheduler for the shared cartridge/ROM memory port on the GX4000/Plus path.
- Arbitrates between three requesters:
  - CPU: read/write.
  - ASIC sound DMA: read-only.
  - Sprite data fetcher: read-only.
- Sequences each access through a fixed-latency memory.
- Returns data with a one-cycle ack pulse per requester.
- Sits between the requesters and the memory block's mem_addr/mem_data/mem_wr/mem_rd/mem_q interface.

Parameters:
- ADDR_W, 23, width of all addresses.
- MEM_LAT, 2, cycles from the mem_rd issue cycle until mem_q is valid (legal range 1..7).
- STARVE_MAX, 4, consecutive CPU grants allowed while DMA or sprite is pending (legal range 1..15).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  CPU read data
- dma_req  in  1  DMA read request
- dma_addr  in  ADDR_W  DMA address
- dma_ack  out  1  completion pulse
- dma_rdata  out  8  DMA read data
- spr_req  in  1  sprite read request
- spr_addr  in  ADDR_W  sprite address
- spr_ack  out  1  completion pulse
- spr_rdata  out  8  sprite read data
- mem_addr  out  ADDR_W  memory address
- mem_data  out  8  memory write data
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_q  in  8  memory read data
- grant  out  2  current owner: 0 none, 1 CPU, 2 DMA, 3 sprite
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (async on reset_n low, all registered):
  - State IDLE.
  - All acks, mem_wr, mem_rd, busy = 0; grant = 0.
  - mem_addr, mem_data, all rdata = 0.
  - Round-robin pointer = DMA; starve counter = 0.
- State machine IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
  - IDLE:
    - If any req is high, arbitrate and latch owner, address, we and wdata.
    - Set grant and go to ISSUE; otherwise stay.
  - ISSUE:
    - One cycle. mem_addr = latched address.
    - Read: mem_rd=1, load the wait counter, then go to WAIT.
    - Write: mem_wr=1 with mem_data=cpu_wdata, then go straight to ACK.
  - WAIT:
    - Count MEM_LAT cycles from the ISSUE cycle.
    - In the cycle where MEM_LAT has elapsed, capture mem_q into the owner's rdata register and go to ACK.
  - ACK: pulse the owner's ack for exactly one cycle, set grant=0, return to IDLE.
- Latency, with the request first seen in IDLE at cycle 0:
  - Read ack at cycle MEM_LAT+2.
  - Write ack at cycle 2.
  - A dead IDLE cycle always follows ACK, so the next ISSUE is 2 cycles after ACK at the earliest.
- rdata registers hold their value until overwritten by that requester's next read. CPU writes do not change cpu_rdata.
- mem_rd and mem_wr are never high together and are never high outside ISSUE.
- mem_addr holds its last value outside ISSUE.
- Arbitration, evaluated in IDLE only:
  - CPU wins unless the starve counter equals STARVE_MAX and DMA or sprite is pending.
  - Among DMA/sprite, the round-robin pointer picks the preferred one if it is requesting, else the other.
  - The pointer flips to the loser after each DMA or sprite grant.
- Starve counter:
  - Increments on each CPU grant while dma_req|spr_req is high, saturating at STARVE_MAX.
  - Clears on any DMA/sprite grant, or when neither is pending.
- Handshake rules:
  - Requesters hold req/addr stable until ack and drop req the cycle after ack.
  - req high in IDLE is always a new request.
  - A req dropped before grant is ignored.
  - A granted access always completes and acks even if req falls.
  - Address and data changes after latch are ignored.
- Reset mid-operation: the in-flight access is abandoned, no ack is generated, and requesters must reissue.

Test Plan:
- CPU read only, MEM_LAT=2, cpu_addr=0x004000, mem_q=0xA5 at the valid cycle:
  - mem_rd at cycle 1; cpu_ack at cycle 4; cpu_rdata=0xA5 held afterwards; grant=1 during cycles 1-3.
- CPU write cpu_addr=0x000010, cpu_wdata=0x3C:
  - mem_wr=1 with mem_addr=0x000010 and mem_data=0x3C at cycle 1; cpu_ack at cycle 2; mem_rd never asserted.
- cpu_req, dma_req and spr_req rise together and each is held until acked:
  - Grant order CPU, DMA, sprite.
  - With dma_req and spr_req then held continuously, grants alternate DMA, sprite, DMA.
- cpu_req held continuously with dma_req high, STARVE_MAX=4:
  - Grants are 4 CPU, 1 DMA, 4 CPU, 1 DMA; the counter reads 0 after each DMA grant.
- reset_n pulsed low during WAIT of a DMA read:
  - All outputs return to reset values in the same cycle; dma_ack never pulses.
  - A re-asserted dma_req after release completes normally.
- Requester drops req in the WAIT cycle after grant:
  - Its ack still pulses once; no second access is issued.
